paddle_controller: RTL

- Sequences one player's paddle for the pong display. Converts debounced left/right button levels into paddle edge positions (state_left, state_right) for the row-display block.
- Drives that block's en input. It blinks the paddle after a miss, then re-centres it.
- Sits between the button conditioning logic and the paddle display row. One instance per player.

---
 rtl/paddle_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/paddle_controller.sv
// Paddle position sequencer for one pong player: button moves with auto-repeat,
// blink-after-miss recovery and re-centring. Outputs are registered.
//   state     | meaning
//   PLAY      | buttons move the paddle, miss starts recovery
//   BLINK_OFF | paddle blanked, counting ticks
//   BLINK_ON  | paddle shown, counting ticks and blink cycles
//   RECENTER  | one cycle: pos back to centre, then PLAY
module paddle_controller #(
    parameter int WIDTH       = 4,
    parameter int BIT_WIDTH   = 2,
    parameter int PAD_LEN     = 2,
    parameter int REPEAT      = 4,
    parameter int BLINK_TICKS = 2,
    parameter int BLINK_COUNT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 miss,
    output logic [BIT_WIDTH-1:0] state_left,
    output logic [BIT_WIDTH-1:0] state_right,
    output logic                 en,
    output logic                 busy
);
    localparam int RPT_W = (REPEAT > 1)      ? $clog2(REPEAT)      : 1;
    localparam int TCK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int BLK_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    localparam logic [BIT_WIDTH-1:0] MAXPOS    = BIT_WIDTH'(WIDTH - PAD_LEN);
    localparam logic [BIT_WIDTH-1:0] CENTER    = BIT_WIDTH'((WIDTH - PAD_LEN) / 2);
    localparam logic [BIT_WIDTH-1:0] RIGHT_OFS = BIT_WIDTH'(PAD_LEN - 1);
    localparam logic [RPT_W-1:0]     RPT_LAST  = RPT_W'(REPEAT - 1);
    localparam logic [TCK_W-1:0]     TCK_LAST  = TCK_W'(BLINK_TICKS - 1);
    localparam logic [BLK_W-1:0]     BLK_LAST  = BLK_W'(BLINK_COUNT - 1);

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        BLINK_OFF = 2'd1,
        BLINK_ON  = 2'd2,
        RECENTER  = 2'd3
    } state_t;

    state_t               r_state;
    logic [BIT_WIDTH-1:0] r_left;
    logic [BIT_WIDTH-1:0] r_right;
    logic                 r_en;
    logic                 r_busy;
    logic [RPT_W-1:0]     r_rpt;
    logic [TCK_W-1:0]     r_tck;
    logic [BLK_W-1:0]     r_blk;
    logic                 r_btn_l_q;
    logic                 r_btn_r_q;

    logic                 w_press_l;
    logic                 w_press_r;
    logic                 w_release;
    logic                 w_both;
    logic                 w_hold_one;
    logic                 w_rpt_clr;
    logic                 w_rpt_fire;
    logic                 w_mv_l;
    logic                 w_mv_r;
    logic [BIT_WIDTH-1:0] w_pos_next;

    assign w_press_l  = btn_left  & ~r_btn_l_q;
    assign w_press_r  = btn_right & ~r_btn_r_q;
    assign w_release  = (~btn_left & r_btn_l_q) | (~btn_right & r_btn_r_q);
    assign w_both     = btn_left & btn_right;
    assign w_hold_one = (btn_left & r_btn_l_q) ^ (btn_right & r_btn_r_q);
    assign w_rpt_clr  = w_press_l | w_press_r | w_release | w_both;
    assign w_rpt_fire = tick & w_hold_one & ~w_rpt_clr & (r_rpt == RPT_LAST);

    // Both buttons high suppresses every move, pressed or repeated.
    assign w_mv_l = ~w_both & (w_press_l | (w_rpt_fire & btn_left));
    assign w_mv_r = ~w_both & (w_press_r | (w_rpt_fire & btn_right));

    always_comb begin
        w_pos_next = r_left;
        if (w_mv_l && (r_left != '0)) begin
            w_pos_next = r_left - 1'b1;
        end else if (w_mv_r && (r_left < MAXPOS)) begin
            w_pos_next = r_left + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PLAY;
            r_left    <= CENTER;
            r_right   <= CENTER + RIGHT_OFS;
            r_en      <= 1'b1;
            r_busy    <= 1'b0;
            r_rpt     <= '0;
            r_tck     <= '0;
            r_blk     <= '0;
            r_btn_l_q <= 1'b0;
            r_btn_r_q <= 1'b0;
        end else begin
            // History tracks in every state so a button held through recovery is not a new press.
            r_btn_l_q <= btn_left;
            r_btn_r_q <= btn_right;
            case (r_state)
                PLAY: begin
                    if (miss) begin
                        r_state <= BLINK_OFF;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_tck   <= '0;
                        r_blk   <= '0;
                    end else begin
                        r_left  <= w_pos_next;
                        r_right <= w_pos_next + RIGHT_OFS;
                        if (w_rpt_clr) begin
                            r_rpt <= '0;
                        end else if (tick && w_hold_one) begin
                            r_rpt <= (r_rpt == RPT_LAST) ? '0 : r_rpt + 1'b1;
                        end
                    end
                end
                BLINK_OFF: begin
                    if (tick) begin
                        if (r_tck == TCK_LAST) begin
                            r_state <= BLINK_ON;
                            r_en    <= 1'b1;
                            r_tck   <= '0;
                        end else begin
                            r_tck <= r_tck + 1'b1;
                        end
                    end
                end
                BLINK_ON: begin
                    if (tick) begin
                        if (r_tck == TCK_LAST) begin
                            r_tck <= '0;
                            if (r_blk == BLK_LAST) begin
                                r_state <= RECENTER;
                                r_blk   <= '0;
                            end else begin
                                r_state <= BLINK_OFF;
                                r_blk   <= r_blk + 1'b1;
                                r_en    <= 1'b0;
                            end
                        end else begin
                            r_tck <= r_tck + 1'b1;
                        end
                    end
                end
                RECENTER: begin
                    r_left  <= CENTER;
                    r_right <= CENTER + RIGHT_OFS;
                    r_rpt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= PLAY;
                end
                default: r_state <= PLAY;
            endcase
        end
    end

    assign state_left  = r_left;
    assign state_right = r_right;
    assign en          = r_en;
    assign busy        = r_busy;
endmodule
